// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and execute-sequencer FSM states shared by decode and EX.
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DONE} state_t;
endpackage

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: op request/result bundle between the EX issue logic and the sequencer.
interface alu_mul_sequencer_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [2:0]      ALUCtrl_i;
  logic [XLEN-1:0] data1_i;
  logic [XLEN-1:0] data2_i;
  logic            flush_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] data_o;
  logic            stall_o;
  modport slave (input start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
                 output ready_o, valid_o, data_o, stall_o);
  modport master (output start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
                  input ready_o, valid_o, data_o, stall_o);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier datapath; one partial product per step, XLEN steps.
module alu_mul_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] prod_o
);
  logic [XLEN-1:0]  a_q, b_q, acc_q;
  logic [CNT_W-1:0] cnt_q;
  // prod_o is the accumulator after the current step, so the final step's sum is visible at once
  assign prod_o = acc_q + (b_q[0] ? a_q : '0);
  assign done_o = step_i && cnt_q == CNT_W'(XLEN - 1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= prod_o;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: EX-stage controller; single-cycle ALU ops, iterative MUL with pipeline stall.
module alu_mul_sequencer import alu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_mul_sequencer_if.slave  bus
);
  state_t          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d, alu_res, prod;
  logic [2:0]      op;
  logic            accept, load, step, done;
  // unlisted codes fall back to ADD
  assign op = (bus.ALUCtrl_i inside {ALU_SUB, ALU_AND, ALU_OR, ALU_MUL}) ? bus.ALUCtrl_i : ALU_ADD;
  assign alu_res = op == ALU_SUB ? bus.data1_i - bus.data2_i :
                   op == ALU_AND ? bus.data1_i & bus.data2_i :
                   op == ALU_OR  ? bus.data1_i | bus.data2_i :
                                   bus.data1_i + bus.data2_i;
  assign bus.ready_o = state_q != S_MUL_RUN;
  assign accept      = bus.start_i && bus.ready_o && !bus.flush_i;
  assign bus.stall_o = state_q == S_MUL_RUN || (accept && op == ALU_MUL);
  assign bus.valid_o = state_q == S_DONE;
  assign bus.data_o  = data_q;
  alu_mul_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .step_i (step),
    .a_i    (bus.data1_i),
    .b_i    (bus.data2_i),
    .done_o (done),
    .prod_o (prod)
  );
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    load    = 1'b0;
    step    = 1'b0;
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else if (state_q == S_MUL_RUN) begin
      step    = 1'b1;
      state_d = done ? S_DONE : S_MUL_RUN;
      data_d  = done ? prod : data_q;
    end else if (accept) begin
      load    = op == ALU_MUL;
      state_d = load ? S_MUL_RUN : S_DONE;
      data_d  = load ? data_q : alu_res;
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
endmodule
